fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Instruction fetch controller for the 16-bit CPU. Owns the program counter, drives the
//   combinational instruction ROM and buffers fetched words in a small prefetch queue.
//   Hands {pc, instr} to decode over a valid/ready handshake. Supports branch redirect
//   (queue flush) and halt/resume sequencing.
// PARAMETERS
//   DEPTH     4        prefetch queue entries; power of 2, >= 2
//   RESET_PC  16'h0000 PC loaded on reset; bit 0 forced to 0
//   PC_STEP   2        byte increment per fetched 16-bit word
// PORTS
//   clk          in   1   system clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   rom_addr     out  16  ROM address = fetch_pc (combinational)
//   rom_data     in   16  ROM read data, valid in the same cycle as rom_addr
//   instr_valid  out  1   queue head holds a valid instruction
//   instr_data   out  16  instruction word at queue head
//   instr_pc     out  16  PC of instr_data
//   instr_ready  in   1   decode accepts head this cycle
//   redirect     in   1   1-cycle pulse: flush queue, load redirect_pc
//   redirect_pc  in   16  branch target; bit 0 ignored
//   halt_req     in   1   pulse: stop fetching
//   resume       in   1   pulse: restart fetching
//   halted       out  1   1 while FSM is in HALTED
// BEHAVIOUR
//   Reset (async): fetch_pc=RESET_PC, queue empty (count=0, rd/wr ptr=0), FSM=BOOT;
//     instr_valid=0, instr_data=0, instr_pc=0, halted=0. Reset mid-operation discards queue.
//   FSM: BOOT -> RUN after exactly one cycle (no fetch in BOOT).
//     RUN -> HALTED on halt_req. HALTED -> RUN on resume. halt_req+resume same cycle: resume wins.
//   Push (RUN, !redirect, and count<DEPTH or pop this cycle): write {fetch_pc, rom_data}
//     at wr ptr; fetch_pc += PC_STEP, 16-bit wrap (16'hFFFE -> 16'h0000).
//   Pop: instr_valid && instr_ready; rd ptr advances. Push+pop together leave count unchanged,
//     legal when full. Outputs come from queue head registers, never from rom_data directly.
//   Latency: first instruction (RESET_PC) has instr_valid=1 in the 2nd cycle after reset
//     release (BOOT, push cycle, valid). Full-rate: 1 instr/cycle when ready held high.
//   Redirect (any state except BOOT; highest priority): at the edge, count=0, ptrs=0,
//     fetch_pc={redirect_pc[15:1],1'b0}; no push and any pop that cycle discarded.
//     instr_valid=0 in the next cycle; target valid 2 cycles after the pulse (if RUN).
//     Redirect in HALTED updates PC and flushes but stays HALTED.
//   HALTED: no push, fetch_pc held; decode may still drain queued entries.
//   halt_req and redirect in the same cycle: both take effect (flush + HALTED).
//   instr_data/instr_pc are don't-care when instr_valid=0; bench must not check them.
// CONFIGURATION
//   FETCH_PERF_EN defined: add ports fetch_count out 16 (pushes), stall_count out 16
//     (RUN cycles with queue full and no pop); both reset to 0, saturate at 16'hFFFF,
//     and are not cleared by redirect.
//   Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//   Reset release, ready=1, ROM[i]=16'hA000+i -> from cycle 2, one instr/cycle, pc 0,2,4..
//   ready=0 for 10 cycles -> exactly DEPTH entries queued, fetch_pc=2*DEPTH; ready=1 -> in order.
//   Redirect to 16'h0031 while queue full -> next cycle valid=0; then pc=16'h0030, none stale.
//   halt_req with 3 queued, ready=1 -> 3 drained, halted=1, rom_addr constant; resume -> next pc.
//   RESET_PC=16'hFFFC, ready=1 -> pcs FFFC, FFFE, 0000, 0002 (wrap).
//   Async reset asserted mid-stream -> instr_valid=0 immediately, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller for the 16-bit CPU.
// Owns the PC, drives the combinational instruction ROM, and buffers fetched
// words in a DEPTH-entry prefetch queue that feeds decode over valid/ready.
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        instr_valid,
  output logic [15:0] instr_data,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
`endif
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam logic [15:0] BOOT_PC = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q;
  logic [15:0]      fetch_pc_q;
  logic [15:0]      q_pc   [DEPTH];
  logic [15:0]      q_data [DEPTH];

  logic flush_c;
  logic pop_c;
  logic push_c;

  // Handshake and flush qualifiers; redirect beats everything, BOOT ignores it
  assign flush_c = redirect && (state_q != S_BOOT);
  assign pop_c   = valid_q && instr_ready;
  assign push_c  = (state_q == S_RUN) && !redirect &&
                   ((count_q < CNT_W'(DEPTH)) || pop_c);

  assign rom_addr    = fetch_pc_q;
  assign instr_valid = valid_q;
  assign instr_data  = q_data[rd_ptr_q];
  assign instr_pc    = q_pc[rd_ptr_q];
  assign halted      = (state_q == S_HALTED);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_BOOT;
    else       state_q <= state_d;
  end

  // FSM next state; resume wins over a simultaneous halt_req
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:   state_d = S_RUN;
      S_RUN:    if (halt_req && !resume) state_d = S_HALTED;
      S_HALTED: if (resume) state_d = S_RUN;
      default:  state_d = S_BOOT;
    endcase
  end

  // Queue occupancy after this cycle's flush/push/pop
  always_comb begin
    count_d = count_q;
    if (flush_c)              count_d = '0;
    else if (push_c && !pop_c) count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
  end

  // Prefetch queue storage, pointers and fetch PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      fetch_pc_q <= BOOT_PC;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      valid_q <= (count_d != '0);
      if (flush_c) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        fetch_pc_q <= redirect_pc & 16'hFFFE;
      end else begin
        if (push_c) begin
          q_pc[wr_ptr_q]   <= fetch_pc_q;
          q_data[wr_ptr_q] <= rom_data;
          wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
          fetch_pc_q       <= fetch_pc_q + 16'(PC_STEP);
        end
        if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_c;
  assign stall_c = (state_q == S_RUN) && (count_q == CNT_W'(DEPTH)) && !pop_c;

  // Saturating performance counters; redirect does not clear them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (push_c && (fetch_count != 16'hFFFF))  fetch_count <= fetch_count + 16'd1;
      if (stall_c && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, table-driven bench for fetch_ctrl.
// Main instance uses RESET_PC=0; a second instance uses RESET_PC=16'hFFFC
// to observe the 16-bit PC wrap after reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rom_addr, rom_data, instr_data, instr_pc, redirect_pc;
  logic        instr_valid, instr_ready, redirect, halt_req, resume, halted;
  logic [15:0] rom_addr2, rom_data2, instr_data2, instr_pc2;
  logic        instr_valid2, halted2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Combinational ROMs: word i holds 16'hA000 + i
  assign rom_data  = 16'hA000 + (rom_addr >> 1);
  assign rom_data2 = 16'hA000 + (rom_addr2 >> 1);

`ifdef FETCH_PERF_EN
  logic [15:0] fc1, sc1, fc2, sc2;
`endif

  fetch_ctrl #(.DEPTH(4), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume(resume), .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_count(fc1), .stall_count(sc1)
`endif
  );

  fetch_ctrl #(.DEPTH(4), .RESET_PC(16'hFFFC), .PC_STEP(2)) dut2 (
    .clk(clk), .reset(reset), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .instr_valid(instr_valid2), .instr_data(instr_data2), .instr_pc(instr_pc2),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .resume(resume), .halted(halted2)
`ifdef FETCH_PERF_EN
    , .fetch_count(fc2), .stall_count(sc2)
`endif
  );

  typedef struct packed {
    logic        rdy;
    logic        redir;
    logic [15:0] rpc;
    logic        hreq;
    logic        res;
    logic        ev;
    logic [15:0] epc;
    logic        eh;
    logic [15:0] eaddr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rdy, logic redir, logic [15:0] rpc, logic hreq,
                              logic res, logic ev, logic [15:0] epc, logic eh,
                              logic [15:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.hreq = hreq; v.res = res;
    v.ev = ev; v.epc = epc; v.eh = eh; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic ev, input logic [15:0] epc,
                            input logic eh, input logic [15:0] eaddr);
    chk({tag, " valid"}, 16'(instr_valid), 16'(ev));
    chk({tag, " halted"}, 16'(halted), 16'(eh));
    chk({tag, " rom_addr"}, rom_addr, eaddr);
    if (ev) begin
      chk({tag, " pc"}, instr_pc, epc);
      chk({tag, " data"}, instr_data, 16'hA000 + (epc >> 1));
    end
  endtask

  task automatic check_head2(input string tag, input logic ev, input logic [15:0] epc,
                             input logic [15:0] eaddr);
    chk({tag, " valid2"}, 16'(instr_valid2), 16'(ev));
    chk({tag, " rom_addr2"}, rom_addr2, eaddr);
    if (ev) begin
      chk({tag, " pc2"}, instr_pc2, epc);
      chk({tag, " data2"}, instr_data2, 16'hA000 + (epc >> 1));
    end
  endtask

  initial begin
    // rdy redir rpc hreq res | ev epc eh eaddr
    // Ten cycles of ready=0: BOOT, then fill DEPTH entries, fetch_pc stalls at 8
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0002));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0004));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0006));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0008));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0008));
    // Drain in order at full rate while refilling (push allowed when full + pop)
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0002, 0, 16'h000A));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0004, 0, 16'h000C));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0006, 0, 16'h000E));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0008, 0, 16'h0010));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0008, 0, 16'h0010));
    // Redirect to 0x0031 with full queue and a pop attempt
    tv.push_back(mk(1, 1, 16'h0031, 0, 0, 0, 16'h0000, 0, 16'h0030));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0030, 0, 16'h0032));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 16'h0030, 0, 16'h0034));
    // halt_req while RUN still pushes that cycle -> 3 queued, then drain
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0030, 1, 16'h0036));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0032, 1, 16'h0036));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0034, 1, 16'h0036));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0036));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0036));
    tv.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0036));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0036, 0, 16'h0038));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0038, 0, 16'h003A));
    // Redirect while HALTED: flush and load PC, stay halted
    tv.push_back(mk(0, 0, 16'h0000, 1, 0, 1, 16'h0038, 1, 16'h003C));
    tv.push_back(mk(0, 1, 16'h0101, 0, 0, 0, 16'h0000, 1, 16'h0100));
    tv.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0100));
    tv.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0, 16'h0100));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0100, 0, 16'h0102));
    // halt_req + redirect together: flush and halt
    tv.push_back(mk(1, 1, 16'h0200, 1, 0, 0, 16'h0000, 1, 16'h0200));
    tv.push_back(mk(1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0200));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0200, 0, 16'h0202));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0202, 0, 16'h0204));
    // halt_req + resume in RUN: resume wins, keeps running
    tv.push_back(mk(1, 0, 16'h0000, 1, 1, 1, 16'h0204, 0, 16'h0206));
    tv.push_back(mk(1, 0, 16'h0000, 0, 0, 1, 16'h0206, 0, 16'h0208));

    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    halt_req = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_head("reset", 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("reset rom_addr2", rom_addr2, 16'hFFFC);
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      instr_ready = tv[i].rdy;
      redirect    = tv[i].redir;
      redirect_pc = tv[i].rpc;
      halt_req    = tv[i].hreq;
      resume      = tv[i].res;
      step();
      check_head($sformatf("v%0d", i), tv[i].ev, tv[i].epc, tv[i].eh, tv[i].eaddr);
    end

    // Async reset mid-stream: outputs drop before any clock edge
    instr_ready = 1'b1; redirect = 1'b0; halt_req = 1'b0; resume = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check_head("midrst", 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("midrst rom_addr2", rom_addr2, 16'hFFFC);
    step();
    reset = 1'b0;

    // Restart at RESET_PC on both instances; dut2 shows the PC wrap
    step();
    check_head("rs1", 1'b0, 16'h0000, 1'b0, 16'h0000);
    check_head2("rs1", 1'b0, 16'h0000, 16'hFFFC);
    step();
    check_head("rs2", 1'b1, 16'h0000, 1'b0, 16'h0002);
    check_head2("rs2", 1'b1, 16'hFFFC, 16'hFFFE);
    step();
    check_head("rs3", 1'b1, 16'h0002, 1'b0, 16'h0004);
    check_head2("rs3", 1'b1, 16'hFFFE, 16'h0000);
    step();
    check_head("rs4", 1'b1, 16'h0004, 1'b0, 16'h0006);
    check_head2("rs4", 1'b1, 16'h0000, 16'h0002);
    step();
    check_head2("rs5", 1'b1, 16'h0002, 16'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
